// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory arbiter
// Purpose: arbitration state encoding plus default widths and starvation
//          limit used by mem_arbiter and anything that instantiates it.
// Ports:   none (package).
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 64;
  localparam int STARVE_MAX_DEF = 4;

  // PRI_D: the data port wins a simultaneous request.
  // PRI_IF: the fetch port wins a simultaneous request.
  typedef enum logic {
    PRI_D  = 1'b0,
    PRI_IF = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter for one single-port memory
// Purpose: grants one of the instruction-fetch and data ports per cycle onto a
//          single-port memory with one-cycle read latency. Data normally wins
//          a conflict; a fetch port denied STARVE_MAX cycles in a row gets
//          priority until it is served once.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   if_req_i/if_addr_i               fetch read request and word address
//   if_gnt_o/if_rvalid_o/if_stall_o  fetch accept, read-data valid, stall
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  data request, write flag, address, data
//   d_gnt_o/d_rvalid_o/d_stall_o     data accept, read-data valid, stall
//   rdata_o                          read data shared by both ports
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i  memory side
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              if_stall_o,
  output logic              d_stall_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt, starve_d;
  logic              if_rvalid_q, d_rvalid_q;

  // Last values driven to the memory, replayed while no port is granted.
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;

  // Grant selection: a lone requester always wins; a conflict is settled by
  // the priority state. Reset suppresses every grant.
  always_comb begin
    if_gnt_o = 1'b0;
    d_gnt_o  = 1'b0;
    if (!rst_i) begin
      if (if_req_i && d_req_i) begin
        if (state_q == PRI_IF) if_gnt_o = 1'b1;
        else                   d_gnt_o  = 1'b1;
      end else begin
        if_gnt_o = if_req_i;
        d_gnt_o  = d_req_i;
      end
    end
  end

  // Memory-side mux; idle cycles hold the previous address/data so the
  // memory pins do not toggle needlessly.
  always_comb begin
    mem_en_o    = if_gnt_o | d_gnt_o;
    mem_addr_o  = addr_q;
    mem_we_o    = we_q & ~rst_i;
    mem_wdata_o = wdata_q;
    if (if_gnt_o) begin
      mem_addr_o = if_addr_i;
      mem_we_o   = 1'b0;
    end else if (d_gnt_o) begin
      mem_addr_o  = d_addr_i;
      mem_we_o    = d_we_i;
      mem_wdata_o = d_wdata_i;
    end
  end

  // Starvation counter and priority FSM next state.
  always_comb begin
    starve_d = '0;
    if (if_req_i && !if_gnt_o) begin
      starve_d = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
    end

    state_d = state_q;
    case (state_q)
      PRI_D:   if (starve_d == CNT_MAX) state_d = PRI_IF;
      PRI_IF:  if (if_gnt_o)            state_d = PRI_D;
      default: state_d = PRI_D;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= PRI_D;
      starve_cnt  <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_cnt  <= starve_d;
      // Fetches are always reads; data writes never produce a response.
      if_rvalid_q <= if_gnt_o;
      d_rvalid_q  <= d_gnt_o & ~d_we_i;
      if (mem_en_o) begin
        addr_q  <= mem_addr_o;
        we_q    <= mem_we_o;
        wdata_q <= mem_wdata_o;
      end
    end
  end

  // A response due in a reset cycle is dropped rather than presented.
  assign if_rvalid_o = if_rvalid_q & ~rst_i;
  assign d_rvalid_o  = d_rvalid_q & ~rst_i;
  assign rdata_o     = mem_rdata_i;

  assign if_stall_o  = if_req_i & ~if_gnt_o;
  assign d_stall_o   = d_req_i & ~d_gnt_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [9:0]  if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic        d_req_i, d_we_i;
  logic [9:0]  d_addr_i;
  logic [63:0] d_wdata_i;
  logic        d_gnt_o, d_rvalid_o;
  logic [63:0] rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [63:0] mem_rdata_i;
  logic        if_stall_o, d_stall_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        is_if;
    logic [63:0] data;
  } sb_entry_t;
  sb_entry_t sb[$];

  logic [63:0] mem [logic [9:0]];
  logic [63:0] ref_mem [logic [9:0]];
  logic [9:0]  last_addr;
  logic        have_last = 1'b0;

  always #5 clk_i = ~clk_i;

  mem_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_gnt_o     (d_gnt_o),
    .d_rvalid_o  (d_rvalid_o),
    .rdata_o     (rdata_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .if_stall_o  (if_stall_o),
    .d_stall_o   (d_stall_o)
  );

  // Unwritten locations read back a fixed address-derived pattern (0x5 -> 0xA5A5).
  function automatic logic [63:0] seed(input logic [9:0] a);
    return 64'h0000_0000_0000_A5A0 ^ {54'd0, a};
  endfunction

  // Single-port synchronous memory, one-cycle read latency.
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
      else mem_rdata_i <= mem.exists(mem_addr_o) ? mem[mem_addr_o] : seed(mem_addr_o);
    end
  end

  function automatic logic [63:0] ref_rd(input logic [9:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [9:0] ia, input logic dr,
                       input logic dw, input logic [9:0] da, input logic [63:0] dd);
    if_req_i  = ir;
    if_addr_i = ia;
    d_req_i   = dr;
    d_we_i    = dw;
    d_addr_i  = da;
    d_wdata_i = dd;
  endtask

  task automatic check_state(input string tag, input arb_state_e st, input logic [2:0] cnt);
    chk({tag, ".state"}, 64'(dut.state_q), 64'(st));
    chk({tag, ".starve"}, 64'(dut.starve_cnt), 64'(cnt));
  endtask

  // One clock cycle: sample at the falling edge, score the response due this
  // cycle, check grants/memory pins, queue the response the grant implies.
  task automatic tick(input string tag, input logic eg_if, input logic eg_d);
    sb_entry_t   e;
    logic        exp_ifv, exp_dv;
    logic [63:0] exp_rd;
    @(negedge clk_i);
    exp_ifv = 1'b0;
    exp_dv  = 1'b0;
    exp_rd  = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!rst_i) begin
        exp_ifv = e.is_if;
        exp_dv  = ~e.is_if;
        exp_rd  = e.data;
      end
    end
    chk({tag, ".if_rvalid"}, 64'(if_rvalid_o), 64'(exp_ifv));
    chk({tag, ".d_rvalid"}, 64'(d_rvalid_o), 64'(exp_dv));
    if (exp_ifv || exp_dv) chk({tag, ".rdata"}, rdata_o, exp_rd);
    chk({tag, ".if_gnt"}, 64'(if_gnt_o), 64'(eg_if));
    chk({tag, ".d_gnt"}, 64'(d_gnt_o), 64'(eg_d));
    chk({tag, ".mem_en"}, 64'(mem_en_o), 64'(eg_if | eg_d));
    chk({tag, ".if_stall"}, 64'(if_stall_o), 64'(if_req_i & ~eg_if));
    chk({tag, ".d_stall"}, 64'(d_stall_o), 64'(d_req_i & ~eg_d));
    if (rst_i) chk({tag, ".mem_we"}, 64'(mem_we_o), 64'd0);
    if (eg_if) begin
      chk({tag, ".mem_addr"}, 64'(mem_addr_o), 64'(if_addr_i));
      chk({tag, ".mem_we"}, 64'(mem_we_o), 64'd0);
      sb.push_back('{is_if: 1'b1, data: ref_rd(if_addr_i)});
      last_addr = if_addr_i;
      have_last = 1'b1;
    end else if (eg_d) begin
      chk({tag, ".mem_addr"}, 64'(mem_addr_o), 64'(d_addr_i));
      chk({tag, ".mem_we"}, 64'(mem_we_o), 64'(d_we_i));
      if (d_we_i) begin
        chk({tag, ".mem_wdata"}, mem_wdata_o, d_wdata_i);
        ref_mem[d_addr_i] = d_wdata_i;
      end else begin
        sb.push_back('{is_if: 1'b0, data: ref_rd(d_addr_i)});
      end
      last_addr = d_addr_i;
      have_last = 1'b1;
    end else if (have_last) begin
      chk({tag, ".mem_addr_hold"}, 64'(mem_addr_o), 64'(last_addr));
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset: requests are ignored and memory controls forced low.
    rst_i = 1'b1;
    drive(1'b0, 10'h0, 1'b1, 1'b1, 10'h3ff, 64'hDEAD);
    tick("rst_req", 1'b0, 1'b0);
    drive(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 64'h0);
    tick("rst_idle", 1'b0, 1'b0);
    rst_i = 1'b0;
    check_state("post_rst", PRI_D, 3'd0);
    tick("idle0", 1'b0, 1'b0);

    // Fetch-only read of 0x005 returns 0xA5A5 one cycle later.
    drive(1'b1, 10'h005, 1'b0, 1'b0, 10'h0, 64'h0);
    tick("f_read", 1'b1, 1'b0);
    drive(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 64'h0);
    tick("f_rsp", 1'b0, 1'b0);

    // Data write then read-back of 0x010.
    drive(1'b0, 10'h0, 1'b1, 1'b1, 10'h010, 64'h1234);
    tick("d_write", 1'b0, 1'b1);
    drive(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 64'h0);
    tick("d_wr_idle", 1'b0, 1'b0);
    drive(1'b0, 10'h0, 1'b1, 1'b0, 10'h010, 64'h0);
    tick("d_rdback", 1'b0, 1'b1);
    drive(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 64'h0);
    tick("d_rb_rsp", 1'b0, 1'b0);

    // Continuous conflict: data x4, fetch on the 5th, data on the 6th.
    drive(1'b1, 10'h020, 1'b1, 1'b0, 10'h030, 64'h0);
    for (int i = 0; i < 4; i++) tick("starve", 1'b0, 1'b1);
    check_state("starved", PRI_IF, 3'd4);
    tick("if_win", 1'b1, 1'b0);
    check_state("after_if", PRI_D, 3'd0);
    tick("d_again", 1'b0, 1'b1);
    check_state("d_again", PRI_D, 3'd1);
    drive(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 64'h0);
    tick("conf_drain", 1'b0, 1'b0);
    check_state("conf_drain", PRI_D, 3'd0);

    // Alternating data/fetch reads, back to back.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 10'h0, 1'b1, 1'b0, 10'(10'h040 + i), 64'h0);
      tick("alt_d", 1'b0, 1'b1);
      drive(1'b1, 10'(10'h050 + i), 1'b0, 1'b0, 10'h0, 64'h0);
      tick("alt_if", 1'b1, 1'b0);
    end
    drive(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 64'h0);
    tick("alt_drain", 1'b0, 1'b0);

    // Fetch alone with starve_cnt at 3: granted, counter clears, no PRI_IF.
    drive(1'b1, 10'h060, 1'b1, 1'b0, 10'h061, 64'h0);
    for (int i = 0; i < 3; i++) tick("pre_alone", 1'b0, 1'b1);
    check_state("cnt3", PRI_D, 3'd3);
    drive(1'b1, 10'h060, 1'b0, 1'b0, 10'h0, 64'h0);
    tick("if_alone", 1'b1, 1'b0);
    check_state("if_alone", PRI_D, 3'd0);
    drive(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 64'h0);
    tick("alone_drain", 1'b0, 1'b0);

    // Reset right after a read grant drops the response.
    drive(1'b1, 10'h070, 1'b1, 1'b0, 10'h071, 64'h0);
    tick("pre_rst", 1'b0, 1'b1);
    check_state("pre_rst", PRI_D, 3'd1);
    rst_i = 1'b1;
    drive(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 64'h0);
    tick("rst_rsp", 1'b0, 1'b0);
    rst_i = 1'b0;
    tick("post_rst2", 1'b0, 1'b0);
    check_state("post_rst2", PRI_D, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, the word address width of the shared memory.
REQ-002 The block SHALL have parameter DATA_W, default 64, the memory word width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, the consecutive fetch denials that force fetch priority.
REQ-004 The block SHALL have port clk_i  input  1  single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port if_req_i  input  1  instruction-fetch read request.
REQ-007 The block SHALL have port if_addr_i  input  ADDR_W  fetch word address.
REQ-008 The block SHALL have port if_gnt_o  output  1  fetch request accepted this cycle.
REQ-009 The block SHALL have port if_rvalid_o  output  1  fetch read data valid.
REQ-010 The block SHALL have port d_req_i  input  1  data-port request.
REQ-011 The block SHALL have port d_we_i  input  1  data-port request is a write (1) or a read (0).
REQ-012 The block SHALL have port d_addr_i  input  ADDR_W  data word address.
REQ-013 The block SHALL have port d_wdata_i  input  DATA_W  data to write.
REQ-014 The block SHALL have port d_gnt_o  output  1  data request accepted this cycle.
REQ-015 The block SHALL have port d_rvalid_o  output  1  data read data valid.
REQ-016 The block SHALL have port rdata_o  output  DATA_W  read data shared by both ports, qualified by the rvalid outputs.
REQ-017 The block SHALL have ports mem_en_o, mem_we_o (output, 1 each), mem_addr_o (output, ADDR_W) and mem_wdata_o (output, DATA_W), which drive the single-port memory.
REQ-018 The block SHALL have port mem_rdata_i  input  DATA_W  memory read data, valid one cycle after mem_en_o with mem_we_o low.
REQ-019 The block SHALL have port if_stall_o  output  1  if_req_i high and if_gnt_o low.
REQ-020 The block SHALL have port d_stall_o  output  1  d_req_i high and d_gnt_o low.

Function
REQ-021 Each requester SHALL hold req, address and write data stable from assertion until a cycle in which its gnt is high.
REQ-022 Grants SHALL be combinational in the request cycle; at most one of if_gnt_o and d_gnt_o SHALL be high in any cycle.
REQ-023 The arbitration FSM SHALL have two states: PRI_D (data wins a conflict) and PRI_IF (fetch wins a conflict).
REQ-024 When exactly one port requests, that port SHALL be granted regardless of FSM state.
REQ-025 When no port requests, no grant SHALL be issued, mem_en_o SHALL be 0, and the memory outputs SHALL hold their previous values.
REQ-026 When a port is granted, mem_en_o SHALL be 1 and mem_addr_o, mem_we_o and mem_wdata_o SHALL come from the granted port; a fetch grant SHALL force mem_we_o to 0.
REQ-027 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment, saturating at STARVE_MAX, in each cycle where if_req_i is 1 and if_gnt_o is 0.
REQ-028 starve_cnt SHALL clear in any cycle where if_gnt_o is 1 or if_req_i is 0.
REQ-029 The FSM SHALL go PRI_D -> PRI_IF at the edge where starve_cnt becomes STARVE_MAX.
REQ-030 The FSM SHALL go PRI_IF -> PRI_D at the edge following any fetch grant.
REQ-031 Read latency SHALL be one cycle: a read grant in cycle N SHALL produce rdata_o equal to mem_rdata_i and the owner's rvalid equal to 1 in cycle N+1.
REQ-032 Back-to-back grants SHALL be allowed, so the sustained throughput is one access per cycle.
REQ-033 A granted data write SHALL never assert any rvalid.
REQ-034 if_rvalid_o and d_rvalid_o SHALL never be high in the same cycle.

Reset
REQ-035 While rst_i is sampled high, the block SHALL load state PRI_D, clear starve_cnt, and clear if_rvalid_o and d_rvalid_o at the next edge.
REQ-036 While rst_i is high, grants, mem_en_o and mem_we_o SHALL be forced to 0.
REQ-037 A reset asserted one cycle after a read grant SHALL discard that response; no rvalid SHALL follow.

Structure
REQ-038 The FSM state enum and the default ADDR_W, DATA_W and STARVE_MAX SHALL live in shared package mem_arb_pkg.
REQ-039 The implementation SHALL be a single module with no sub-modules; the grant mux, FSM, starvation counter and response register SHALL all be in mem_arbiter.

Verification
REQ-040 Directed test: fetch-only read at addr 0x005, memory returns 0xA5A5 -> if_gnt_o=1 in cycle N; if_rvalid_o=1 and rdata_o=0xA5A5 in N+1.
REQ-041 Directed test: data write at 0x010 with 0x1234 -> mem_we_o=1 with 0x1234 on mem_wdata_o; no rvalid on either port.
REQ-042 Directed test: both ports request continuously, STARVE_MAX=4 -> data granted 4 cycles, fetch granted in cycle 5, data in cycle 6; if_stall_o=1 during cycles 1-4.
REQ-043 Directed test: alternating data read / fetch read every cycle -> rvalid alternates d, if, d, if with no gap and is never high on both ports.
REQ-044 Directed test: rst_i asserted in the cycle after a read grant -> both rvalid outputs 0, state PRI_D, starve_cnt 0.
REQ-045 Directed test: fetch requests alone while starve_cnt=3 -> fetch granted, starve_cnt clears to 0, no state change to PRI_IF.
